// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// master: memory-stage requester plus memory model; slave: the load_store_unit.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWrite;
    logic [1:0]            reqSize;
    logic                  reqSigned;
    logic [ADDR_WIDTH-1:0] reqAddress;
    logic [DATA_WIDTH-1:0] reqData;
    logic                  respValid;
    logic                  respError;
    logic [DATA_WIDTH-1:0] respData;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic                  memRead;
    logic                  memWrite;
    logic [DATA_WIDTH-1:0] memReadData;
    logic                  memAck;

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData,
        output memReadData, memAck,
        input  reqReady, respValid, respError, respData,
        input  memAddress, memWriteData, memRead, memWrite
    );

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData,
        input  memReadData, memAck,
        output reqReady, respValid, respError, respData,
        output memAddress, memWriteData, memRead, memWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, little-endian lane extract and sign/zero extend.
// Build option LSU_SUBWORD_STORE_EN: sub-doubleword stores via read-modify-write; otherwise they return an error.
module load_store_unit #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    load_store_unit_if.slave bus
);

`ifdef LSU_SUBWORD_STORE_EN
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ACCESS, RESP} state_t;
`endif

    typedef struct packed {
        logic                  write;
        logic [1:0]            size;
        logic                  sgn;
        logic [2:0]            offset;
`ifdef LSU_SUBWORD_STORE_EN
        logic [DATA_WIDTH-1:0] data;
`endif
    } req_t;

    state_t                state_q;
    req_t                  req_q;
    logic                  reqReady_q;
    logic                  respValid_q;
    logic                  respError_q;
    logic [DATA_WIDTH-1:0] respData_q;
    logic                  memRead_q;
    logic                  memWrite_q;
    logic [ADDR_WIDTH-1:0] memAddress_q;
    logic [DATA_WIDTH-1:0] memWriteData_q;

    logic misalign;
    logic unsupported;
    logic req_err;
    req_t req_d;

    function automatic logic [DATA_WIDTH-1:0] load_lane(input logic [DATA_WIDTH-1:0] word,
                                                        input req_t r);
        logic [DATA_WIDTH-1:0] sh;
        sh = word >> {r.offset, 3'b000};
        case (r.size)
            2'b00:   load_lane = r.sgn ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]}   : DATA_WIDTH'(sh[7:0]);
            2'b01:   load_lane = r.sgn ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]} : DATA_WIDTH'(sh[15:0]);
            2'b10:   load_lane = r.sgn ? {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]} : DATA_WIDTH'(sh[31:0]);
            default: load_lane = sh;
        endcase
    endfunction

`ifdef LSU_SUBWORD_STORE_EN
    function automatic logic [DATA_WIDTH-1:0] merge_lane(input logic [DATA_WIDTH-1:0] word,
                                                         input req_t r);
        logic [DATA_WIDTH-1:0] m;
        case (r.size)
            2'b00:   m = DATA_WIDTH'(8'hFF);
            2'b01:   m = DATA_WIDTH'(16'hFFFF);
            2'b10:   m = DATA_WIDTH'(32'hFFFF_FFFF);
            default: m = '1;
        endcase
        merge_lane = (word & ~(m << {r.offset, 3'b000})) | ((r.data & m) << {r.offset, 3'b000});
    endfunction

    assign unsupported = 1'b0;
`else
    // Without the RMW path only full-doubleword stores can be written.
    assign unsupported = bus.reqWrite && (bus.reqSize != 2'b11);
`endif

    always_comb begin
        misalign = 1'b0;
        case (bus.reqSize)
            2'b01:   misalign = bus.reqAddress[0];
            2'b10:   misalign = |bus.reqAddress[1:0];
            2'b11:   misalign = |bus.reqAddress[2:0];
            default: misalign = 1'b0;
        endcase
    end

    assign req_err = misalign | unsupported;

    always_comb begin
        req_d        = '0;
        req_d.write  = bus.reqWrite;
        req_d.size   = bus.reqSize;
        req_d.sgn    = bus.reqSigned;
        req_d.offset = bus.reqAddress[2:0];
`ifdef LSU_SUBWORD_STORE_EN
        req_d.data   = bus.reqData;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= IDLE;
            req_q          <= '0;
            reqReady_q     <= 1'b0;
            respValid_q    <= 1'b0;
            respError_q    <= 1'b0;
            respData_q     <= '0;
            memRead_q      <= 1'b0;
            memWrite_q     <= 1'b0;
            memAddress_q   <= '0;
            memWriteData_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!reqReady_q) begin
                        reqReady_q <= 1'b1;
                    end else if (bus.reqValid) begin
                        reqReady_q   <= 1'b0;
                        req_q        <= req_d;
                        memAddress_q <= {bus.reqAddress[ADDR_WIDTH-1:3], 3'b000};
                        if (req_err) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respError_q <= 1'b1;
                            respData_q  <= '0;
                        end else if (!bus.reqWrite || bus.reqSize == 2'b11) begin
                            state_q    <= ACCESS;
                            memRead_q  <= !bus.reqWrite;
                            memWrite_q <= bus.reqWrite;
                            if (bus.reqWrite) memWriteData_q <= bus.reqData;
                        end
`ifdef LSU_SUBWORD_STORE_EN
                        else begin
                            state_q   <= RMW_READ;
                            memRead_q <= 1'b1;
                        end
`endif
                    end
                end
                ACCESS: begin
                    if (bus.memAck) begin
                        state_q     <= RESP;
                        memRead_q   <= 1'b0;
                        memWrite_q  <= 1'b0;
                        respValid_q <= 1'b1;
                        respError_q <= 1'b0;
                        respData_q  <= req_q.write ? '0 : load_lane(bus.memReadData, req_q);
                    end
                end
`ifdef LSU_SUBWORD_STORE_EN
                RMW_READ: begin
                    if (bus.memAck) begin
                        state_q        <= RMW_WRITE;
                        memRead_q      <= 1'b0;
                        memWrite_q     <= 1'b1;
                        memWriteData_q <= merge_lane(bus.memReadData, req_q);
                    end
                end
                RMW_WRITE: begin
                    if (bus.memAck) begin
                        state_q     <= RESP;
                        memWrite_q  <= 1'b0;
                        respValid_q <= 1'b1;
                        respError_q <= 1'b0;
                        respData_q  <= '0;
                    end
                end
`endif
                RESP: begin
                    state_q     <= IDLE;
                    respValid_q <= 1'b0;
                    respError_q <= 1'b0;
                    respData_q  <= '0;
                    reqReady_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.reqReady     = reqReady_q;
    assign bus.respValid    = respValid_q;
    assign bus.respError    = respError_q;
    assign bus.respData     = respData_q;
    assign bus.memRead      = memRead_q;
    assign bus.memWrite     = memWrite_q;
    assign bus.memAddress   = memAddress_q;
    assign bus.memWriteData = memWriteData_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: responses checked against a queue filled at request time,
// strobe timing checked cycle by cycle against a small doubleword memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus();

    load_store_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    // memory model: 16 doublewords indexed by address bits [6:3]
    logic [63:0] mem [0:15];
    logic        mem_init = 1'b0;
    assign bus.memReadData = mem[bus.memAddress[6:3]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
            mem[1]   <= 64'h8000_0001_0000_0000;
            mem[2]   <= 64'h2222_2222_2222_2222;
            mem[3]   <= 64'h3333_3333_3333_3333;
            mem[5]   <= 64'h5555_5555_5555_5555;
            mem_init <= 1'b1;
        end else if (bus.memWrite && bus.memAck) begin
            mem[bus.memAddress[6:3]] <= bus.memWriteData;
        end
    end

    typedef struct {
        logic        err;
        logic [63:0] data;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.respValid) begin
            if (sb.size() == 0) begin
                chk("unexp_resp", {63'd0, bus.respValid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_err"}, {63'd0, bus.respError}, {63'd0, e.err});
                chk({e.tag, "_data"}, bus.respData, e.data);
            end
        end
        if (bus.memRead || bus.memWrite)
            chk("strobe_excl", {63'd0, bus.memRead & bus.memWrite}, 64'd0);
    end

    // call at a falling edge; returns 1ns after the accepting rising edge
    task automatic send(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic eerr, input logic [63:0] edata, input bit push);
        int t = 0;
        while (!bus.reqReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk({tag, "_rdy_timeout"}, {63'd0, bus.reqReady}, 64'd1);
        bus.reqWrite   = w;
        bus.reqSize    = sz;
        bus.reqSigned  = sg;
        bus.reqAddress = a;
        bus.reqData    = d;
        bus.reqValid   = 1'b1;
        if (push) sb.push_back('{eerr, edata, tag});
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int t = 0;
        @(negedge clk);
        while (!bus.respValid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_resp_seen"}, {63'd0, bus.respValid}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.reqValid   = 1'b0;
        bus.reqWrite   = 1'b0;
        bus.reqSize    = 2'b00;
        bus.reqSigned  = 1'b0;
        bus.reqAddress = 64'd0;
        bus.reqData    = 64'd0;
        bus.memAck     = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_reqReady",  {63'd0, bus.reqReady},  64'd0);
        chk("rst_respValid", {63'd0, bus.respValid}, 64'd0);
        chk("rst_respError", {63'd0, bus.respError}, 64'd0);
        chk("rst_respData",  bus.respData,           64'd0);
        chk("rst_strobes",   {62'd0, bus.memRead, bus.memWrite}, 64'd0);
        chk("rst_memAddr",   bus.memAddress,         64'd0);
        chk("rst_memWdata",  bus.memWriteData,       64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {63'd0, bus.reqReady}, 64'd1);

        // doubleword load: strobe N+1, response N+2, ready N+3
        send("ld64", 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 1'b0, 64'h2222_2222_2222_2222, 1'b1);
        @(negedge clk);
        chk("ld64_rd",   {63'd0, bus.memRead}, 64'd1);
        chk("ld64_addr", bus.memAddress, 64'h10);
        @(negedge clk);
        chk("ld64_rv",   {63'd0, bus.respValid}, 64'd1);
        chk("ld64_strb", {62'd0, bus.memRead, bus.memWrite}, 64'd0);
        @(negedge clk);
        chk("ld64_rdy",  {63'd0, bus.reqReady}, 64'd1);
        chk("ld64_rv0",  {63'd0, bus.respValid}, 64'd0);

        // sub-doubleword loads out of 0x8000000100000000 at 0x08
        send("lw_s", 1'b0, 2'b10, 1'b1, 64'h0C, 64'd0, 1'b0, 64'hFFFF_FFFF_8000_0001, 1'b1);
        @(negedge clk);
        chk("lw_s_addr", bus.memAddress, 64'h08);
        wait_resp("lw_s");
        send("lw_u", 1'b0, 2'b10, 1'b0, 64'h0C, 64'd0, 1'b0, 64'h0000_0000_8000_0001, 1'b1);
        wait_resp("lw_u");
        send("lb_s7", 1'b0, 2'b00, 1'b1, 64'h0F, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        wait_resp("lb_s7");
        send("lh_u6", 1'b0, 2'b01, 1'b0, 64'h0E, 64'd0, 1'b0, 64'h0000_0000_0000_8000, 1'b1);
        wait_resp("lh_u6");
        send("lb_s4", 1'b0, 2'b00, 1'b1, 64'h0C, 64'd0, 1'b0, 64'h0000_0000_0000_0001, 1'b1);
        wait_resp("lb_s4");

        // misaligned half load: error in N+1, no strobe
        send("lh_mis", 1'b0, 2'b01, 1'b0, 64'h05, 64'd0, 1'b1, 64'd0, 1'b1);
        @(negedge clk);
        chk("lh_mis_rv",   {63'd0, bus.respValid}, 64'd1);
        chk("lh_mis_strb", {62'd0, bus.memRead, bus.memWrite}, 64'd0);

`ifdef LSU_SUBWORD_STORE_EN
        send("sb", 1'b1, 2'b00, 1'b0, 64'h1B, 64'hDEAD_BEEF_0000_00AB, 1'b0, 64'd0, 1'b1);
        @(negedge clk);
        chk("sb_rd",    {63'd0, bus.memRead}, 64'd1);
        chk("sb_raddr", bus.memAddress, 64'h18);
        @(negedge clk);
        chk("sb_wr",    {62'd0, bus.memRead, bus.memWrite}, 64'd1);
        chk("sb_waddr", bus.memAddress, 64'h18);
        chk("sb_wdata", bus.memWriteData, 64'h3333_3333_AB33_3333);
        @(negedge clk);
        chk("sb_rv",    {63'd0, bus.respValid}, 64'd1);
        send("sb_rb", 1'b0, 2'b11, 1'b0, 64'h18, 64'd0, 1'b0, 64'h3333_3333_AB33_3333, 1'b1);
        wait_resp("sb_rb");
        send("sh", 1'b1, 2'b01, 1'b0, 64'h08, 64'h1234_BEEF, 1'b0, 64'd0, 1'b1);
        wait_resp("sh");
        send("sh_rb", 1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 1'b0, 64'h8000_0001_0000_BEEF, 1'b1);
        wait_resp("sh_rb");
`else
        send("sb", 1'b1, 2'b00, 1'b0, 64'h1B, 64'hDEAD_BEEF_0000_00AB, 1'b1, 64'd0, 1'b1);
        @(negedge clk);
        chk("sb_rv",   {63'd0, bus.respValid}, 64'd1);
        chk("sb_strb", {62'd0, bus.memRead, bus.memWrite}, 64'd0);
        send("sb_rb", 1'b0, 2'b11, 1'b0, 64'h18, 64'd0, 1'b0, 64'h3333_3333_3333_3333, 1'b1);
        wait_resp("sb_rb");
        send("sh", 1'b1, 2'b01, 1'b0, 64'h08, 64'h1234_BEEF, 1'b1, 64'd0, 1'b1);
        @(negedge clk);
        chk("sh_rv",   {63'd0, bus.respValid}, 64'd1);
        chk("sh_strb", {62'd0, bus.memRead, bus.memWrite}, 64'd0);
        send("sh_rb", 1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 1'b0, 64'h8000_0001_0000_0000, 1'b1);
        wait_resp("sh_rb");
`endif

        // doubleword store with ack held low for three cycles
        @(negedge clk);
        bus.memAck = 1'b0;
        send("sd_wait", 1'b1, 2'b11, 1'b0, 64'h20, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sd_wait_wr",    {62'd0, bus.memRead, bus.memWrite}, 64'd1);
            chk("sd_wait_addr",  bus.memAddress, 64'h20);
            chk("sd_wait_wdata", bus.memWriteData, 64'h0123_4567_89AB_CDEF);
            if (i == 3) bus.memAck = 1'b1;
        end
        @(negedge clk);
        chk("sd_wait_rv", {63'd0, bus.respValid}, 64'd1);
        send("sd_rb", 1'b0, 2'b11, 1'b0, 64'h20, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
        wait_resp("sd_rb");

        // same store interrupted by reset: strobe drops at once, no response, nothing written
        @(negedge clk);
        bus.memAck = 1'b0;
        send("sd_rst", 1'b1, 2'b11, 1'b0, 64'h28, 64'hCAFE_F00D_CAFE_F00D, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        chk("sd_rst_wr", {63'd0, bus.memWrite}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("sd_rst_wr0",  {63'd0, bus.memWrite},  64'd0);
        chk("sd_rst_rv0",  {63'd0, bus.respValid}, 64'd0);
        chk("sd_rst_rdy0", {63'd0, bus.reqReady},  64'd0);
        bus.memAck = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sd_rst_rdy1", {63'd0, bus.reqReady}, 64'd1);
        repeat (3) @(negedge clk);
        chk("sd_rst_mem", mem[5], 64'h5555_5555_5555_5555);

        send("ld_post", 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 1'b0, 64'h2222_2222_2222_2222, 1'b1);
        wait_resp("ld_post");
        repeat (2) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU data-memory port. Accepts one load or store at a time from the memory stage, drives the 64-bit doubleword data memory via a read/write strobe interface with an acknowledge, and returns a single-cycle response. Performs little-endian lane extraction and sign/zero extension for loads. Merges sub-doubleword stores with a read-modify-write sequence.

## Interface
- ADDR_WIDTH, 64, byte-address width
- DATA_WIDTH, 64, memory word width; fixed at 64
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- reqValid  in  1  request present
- reqReady  out  1  unit can accept; transfer on reqValid && reqReady at rising edge
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 half, 10 word, 11 doubleword
- reqSigned  in  1  sign-extend load result; ignored for stores and size 11
- reqAddress  in  ADDR_WIDTH  byte address
- reqData  in  64  store data, right-justified
- respValid  out  1  one-cycle completion pulse
- respError  out  1  valid with respValid; misaligned or unsupported
- respData  out  64  load result; 0 for stores and errors
- memAddress  out  ADDR_WIDTH  always {reqAddress[63:3], 3'b000}
- memWriteData  out  64  full doubleword to write
- memRead  out  1  read strobe
- memWrite  out  1  write strobe
- memReadData  in  64  read data, valid when memAck high
- memAck  in  1  memory completes current strobe this cycle; may be tied 1

## Operation
- States: IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP.
- IDLE: reqReady=1. On accept, latch all req fields. Misaligned (address not a multiple of the size) -> RESP with error. Load or doubleword store -> ACCESS. Sub-doubleword store -> RMW_READ.
- ACCESS: memRead=!reqWrite, memWrite=reqWrite. On memAck -> RESP. Loads capture memReadData.
- RMW_READ: memRead=1. On memAck, capture the word. Replace the lane (offset = addr[2:0], bits 8*offset upward, size bytes) with reqData low bytes -> RMW_WRITE.
- RMW_WRITE: memWrite=1, memWriteData=merged word. On memAck -> RESP.
- RESP: respValid=1 for exactly one cycle. No backpressure. -> IDLE.
- Load result: lane extracted from the captured word. Zero-extended, or sign-extended from the lane MSB when reqSigned.
- memRead and memWrite are never both 1.
- memAddress and memWriteData are held stable while either strobe is high.
- Strobes are 0 in IDLE and RESP.
- reqReady=0 in every state except IDLE.

## Timing
- Reset values: reqReady=0, respValid=0, respError=0, respData=0, memRead=0, memWrite=0, memAddress=0, memWriteData=0. State=IDLE.
- reqReady goes to 1 on the first clock edge after reset_n deasserts.
- All outputs are registered or decoded from registered state.
- With memAck tied 1, accept at edge N:
  - load or doubleword store: strobe in cycle N+1, respValid in N+2, reqReady in N+3.
  - RMW store: read in N+1, write in N+2, respValid in N+3.
  - error: respValid in N+1, no strobe.
- memAck low extends the current strobe indefinitely. No timeout.
- memAck is ignored in IDLE and RESP.
- reset_n low mid-operation: all strobes and respValid drop immediately (asynchronous). The pending request is discarded; no response is ever issued for it.

## Configuration
- LSU_SUBWORD_STORE_EN defined: sub-doubleword stores use RMW_READ and RMW_WRITE as above.
- LSU_SUBWORD_STORE_EN undefined: RMW states are not built. Sub-doubleword stores complete as RESP with respError=1 and no memory strobe. Loads of every size remain supported.

## Test plan
- Doubleword load: reqAddress=0x10, memAck=1, memReadData=0x2222222222222222.
  -> memRead=1 with memAddress=0x10 in N+1; respValid in N+2 with respData=0x2222222222222222, respError=0.
- Signed word load: reqAddress=0x0C, reqSize=10, reqSigned=1, memReadData=0x8000000100000000.
  -> memAddress=0x08, respData=0xFFFFFFFF80000001. With reqSigned=0 -> 0x0000000080000001.
- Byte store (macro defined): reqAddress=0x1B, reqData=0xAB, memory word=0x3333333333333333.
  -> memRead at 0x18, then memWrite at 0x18 with memWriteData=0x33333333AB333333; respValid in N+3.
- Misaligned half load at 0x05.
  -> respValid and respError=1 in N+1, respData=0, memRead and memWrite stay 0.
- Doubleword store to 0x20 with memAck held low 3 cycles.
  -> memWrite and memAddress=0x20 stable for 4 cycles, respValid one cycle later.
  - Repeat with reset_n pulsed low during the wait -> memWrite drops immediately, no respValid, reqReady=1 one edge after release.
- Macro undefined: halfword store to 0x08.
  -> respError=1 in N+1, no strobe.
